// File: rtl/gao_vio_driver.sv
// gao_vio_driver: JTAG-driven virtual input probes, the write-side companion to the GAO capture path.
// The ER2 user-register signals are oversampled in clk. LEN shifted bits are assembled in a shadow
// register, their count is checked, and they are committed to probe_o atomically on update.
// The current probe_o value is shifted back out on tdo_o so the host can read it.
// Optional feature macro: VIO_PULSE_EN. When it is defined, one extra MSB mode bit selects a
// PULSE_LEN-cycle pulse commit instead of a level commit.
module gao_vio_driver #(
    parameter int               WIDTH       = 7,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               PULSE_LEN   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tck_i,
    input  logic             tdi_i,
    input  logic             enable_i,
    input  logic             shift_i,
    input  logic             update_i,
    output logic             tdo_o,
    output logic [WIDTH-1:0] probe_o,
    output logic             probe_valid_o,
    output logic             len_err_o
);

`ifdef VIO_PULSE_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif
    localparam int CW = $clog2(LEN + 2);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_UPDATE  = 2'd3;

    if (SYNC_STAGES < 2 || PULSE_LEN < 1) begin : g_bad_param
        $error("gao_vio_driver: SYNC_STAGES must be >= 2 and PULSE_LEN >= 1");
    end

    // Synchronizer bit order: {tck, tdi, enable, shift, update}
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [2:0]                  edge_q;   // delayed {tck, shift, update} for edge detection
    logic [4:0]                  jtag_s;
    logic                        tck_s, tdi_s, en_s, shift_s, upd_s;
    logic                        tck_rise, tck_fall, shift_rise, update_rise;

    assign jtag_s = sync_q[SYNC_STAGES-1];
    assign tck_s   = jtag_s[4];
    assign tdi_s   = jtag_s[3];
    assign en_s    = jtag_s[2];
    assign shift_s = jtag_s[1];
    assign upd_s   = jtag_s[0];

    assign tck_rise    =  tck_s   & ~edge_q[2];
    assign tck_fall    = ~tck_s   &  edge_q[2];
    assign shift_rise  =  shift_s & ~edge_q[1];
    assign update_rise =  upd_s   & ~edge_q[0];

    // Bring the asynchronous TAP signals into clk and keep one more copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= {tck_i, tdi_i, enable_i, shift_i, update_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            edge_q <= {tck_s, shift_s, upd_s};
        end
    end

    logic [1:0]     state;
    logic [LEN-1:0] shadow;
    logic [CW-1:0]  bit_cnt;
    logic           commit_ok, commit_bad;

    assign commit_ok  = (state == ST_UPDATE) && (bit_cnt == CW'(LEN));
    assign commit_bad = (state == ST_UPDATE) && (bit_cnt != CW'(LEN));

    // Capture/shift/update sequencing; the shadow only ever feeds probe_o through UPDATE
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shadow  <= '0;
            bit_cnt <= '0;
            tdo_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (shift_rise && en_s) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    shadow  <= LEN'(probe_o);
                    bit_cnt <= '0;
                    tdo_o   <= probe_o[0];
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!en_s) begin
                        // Deselected: drop the partial word
                        shadow  <= '0;
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else if (shift_rise) begin
                        state <= ST_CAPTURE;
                    end else begin
                        if (tck_rise && shift_s) begin
                            shadow <= {tdi_s, shadow[LEN-1:1]};
                            if (bit_cnt != CW'(LEN + 1)) bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (tck_fall) tdo_o <= shadow[0];
                        // A same-cycle tck_rise is applied above before the count is checked
                        if (update_rise) state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VIO_PULSE_EN
    localparam int PW = $clog2(PULSE_LEN + 1);
    logic [WIDTH-1:0] level_q;
    logic [PW-1:0]    pulse_cnt;

    // Commit with optional timed pulse; level_q is the value probe_o reverts to
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_o       <= RESET_VAL;
            level_q       <= RESET_VAL;
            pulse_cnt     <= '0;
            probe_valid_o <= 1'b0;
            len_err_o     <= 1'b0;
        end else begin
            probe_valid_o <= commit_ok;
            len_err_o     <= commit_bad;
            if (commit_ok) begin
                probe_o <= shadow[WIDTH-1:0];
                if (shadow[WIDTH]) begin
                    pulse_cnt <= PW'(PULSE_LEN);
                end else begin
                    level_q   <= shadow[WIDTH-1:0];
                    pulse_cnt <= '0;
                end
            end else if (pulse_cnt == PW'(1)) begin
                probe_o   <= level_q;
                pulse_cnt <= '0;
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
    end
`else
    // Level commit: probe_o takes the shadow only on a correctly sized update
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_o       <= RESET_VAL;
            probe_valid_o <= 1'b0;
            len_err_o     <= 1'b0;
        end else begin
            probe_valid_o <= commit_ok;
            len_err_o     <= commit_bad;
            if (commit_ok) probe_o <= shadow[WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_gao_vio_driver.sv
// Bench for gao_vio_driver: a table of directed transactions, hand-written corner sequences and
// randomized transactions checked against a transaction-level model of the probe register.
module tb_gao_vio_driver;
    localparam int W    = 7;
    localparam int SS   = 2;
    localparam int PL   = 16;
    localparam int HALF = 6;   // clk cycles per tck half period
    localparam logic [W-1:0] RV = '0;
`ifdef VIO_PULSE_EN
    localparam int LEN = W + 1;
`else
    localparam int LEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst, tck_i, tdi_i, enable_i, shift_i, update_i;
    logic         tdo_o, probe_valid_o, len_err_o;
    logic [W-1:0] probe_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gao_vio_driver #(.WIDTH(W), .SYNC_STAGES(SS), .RESET_VAL(RV), .PULSE_LEN(PL)) dut (
        .clk(clk), .rst(rst), .tck_i(tck_i), .tdi_i(tdi_i), .enable_i(enable_i),
        .shift_i(shift_i), .update_i(update_i), .tdo_o(tdo_o), .probe_o(probe_o),
        .probe_valid_o(probe_valid_o), .len_err_o(len_err_o)
    );

    typedef struct {
        logic [15:0]  data;
        int           dn;        // shift length relative to LEN
        logic         exp_valid;
        logic         exp_err;
        logic [W-1:0] exp_probe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic capture();
        shift_i = 1'b0; tck_i = 1'b0; update_i = 1'b0;
        ticks(4);
        enable_i = 1'b1;
        ticks(2);
        shift_i = 1'b1;
        ticks(HALF);
    endtask

    // Clock n bits out LSB-first; rb collects tdo_o sampled just before each tck rise
    task automatic shift_bits(input logic [15:0] d, input int n, output logic [15:0] rb);
        rb = '0;
        for (int i = 0; i < n; i++) begin
            tdi_i = d[i];
            ticks(HALF);
            rb[i] = tdo_o;
            tck_i = 1'b1;
            ticks(HALF);
            tck_i = 1'b0;
        end
        ticks(HALF);
    endtask

    // update_i was just raised: watch a bounded window for the result pulses
    task automatic watch(output int nv, output int ne, output int lat);
        nv = 0; ne = 0; lat = -1;
        for (int k = 1; k <= 24; k++) begin
            ticks(1);
            if (probe_valid_o) begin
                nv++;
                if (lat < 0) lat = k;
            end
            if (len_err_o) ne++;
        end
        update_i = 1'b0; tck_i = 1'b0; shift_i = 1'b0;
        ticks(HALF);
    endtask

    task automatic do_update(output int nv, output int ne, output int lat);
        update_i = 1'b1;
        watch(nv, ne, lat);
    endtask

    // One full transaction against the model value cur; cur is advanced on an accepted commit
    task automatic run_txn(input string tag, input logic [15:0] d, input int n,
                           input logic ev, input logic ee, input logic [W-1:0] ep,
                           inout logic [W-1:0] cur);
        logic [15:0] rb, m;
        int nv, ne, lat, k;
        k = (n < W) ? n : W;
        m = 16'((32'd1 << k) - 1);
        capture();
        shift_bits(d, n, rb);
        check({tag, "_hold"}, probe_o, cur);
        check({tag, "_readback"}, rb & m, 16'(cur) & m);
        do_update(nv, ne, lat);
        check({tag, "_valid"}, nv, ev);
        check({tag, "_err"}, ne, ee);
        check({tag, "_probe"}, probe_o, ep);
        if (ev) check({tag, "_latency"}, lat, SS + 2);
        cur = ep;
    endtask

    initial begin
        vec_t         tbl [6];
        logic [W-1:0] cur;
        logic [15:0]  rb, d;
        int           nv, ne, lat, n, r, cnt;

        tbl[0] = '{16'h005A,  0, 1'b1, 1'b0, 7'h5A};
        tbl[1] = '{16'h0000,  0, 1'b1, 1'b0, 7'h00};
        tbl[2] = '{16'h0033, -1, 1'b0, 1'b1, 7'h00};
        tbl[3] = '{16'h0033,  1, 1'b0, 1'b1, 7'h00};
        tbl[4] = '{16'h007F,  0, 1'b1, 1'b0, 7'h7F};
        tbl[5] = '{16'h002C,  0, 1'b1, 1'b0, 7'h2C};

        rst = 1'b1; tck_i = 0; tdi_i = 0; enable_i = 0; shift_i = 0; update_i = 0;
        ticks(3);
        rst = 1'b0;

        // Reset state and quiet idle
        nv = 0; ne = 0;
        for (int i = 0; i < 20; i++) begin
            ticks(1);
            nv += int'(probe_valid_o);
            ne += int'(len_err_o);
        end
        check("rst_probe", probe_o, RV);
        check("rst_tdo", tdo_o, 0);
        check("rst_valid_pulses", nv, 0);
        check("rst_err_pulses", ne, 0);
        cur = RV;

        // Directed table
        for (int i = 0; i < 6; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].data, LEN + tbl[i].dn,
                    tbl[i].exp_valid, tbl[i].exp_err, tbl[i].exp_probe, cur);

        // Update while idle is ignored
        enable_i = 1'b1;
        do_update(nv, ne, lat);
        check("idle_upd_valid", nv, 0);
        check("idle_upd_err", ne, 0);
        check("idle_upd_probe", probe_o, cur);

        // Deselect mid-shift, then update: nothing happens, and FSM is idle afterwards
        capture();
        shift_bits(16'h0015, 3, rb);
        enable_i = 1'b0;
        ticks(HALF);
        do_update(nv, ne, lat);
        check("drop_en_valid", nv, 0);
        check("drop_en_err", ne, 0);
        check("drop_en_probe", probe_o, cur);
        enable_i = 1'b1;
        ticks(4);
        do_update(nv, ne, lat);
        check("drop_en_idle_valid", nv, 0);
        check("drop_en_idle_err", ne, 0);

        // Re-capture without update reloads the shadow and clears the count
        capture();
        shift_bits(16'h0015, 3, rb);
        shift_i = 1'b0;
        ticks(HALF);
        shift_i = 1'b1;
        ticks(HALF);
        shift_bits(16'h004B, LEN, rb);
        check("recap_readback", rb[W-1:0], cur);
        do_update(nv, ne, lat);
        check("recap_valid", nv, 1);
        check("recap_err", ne, 0);
        check("recap_probe", probe_o, 7'h4B);
        cur = 7'h4B;

        // Last tck rise coincides with update rise: the bit counts
        d = 16'h0066;
        capture();
        shift_bits(d, LEN - 1, rb);
        tdi_i = d[LEN-1];
        ticks(HALF);
        tck_i = 1'b1;
        update_i = 1'b1;
        watch(nv, ne, lat);
        check("simul_valid", nv, 1);
        check("simul_err", ne, 0);
        check("simul_latency", lat, SS + 2);
        check("simul_probe", probe_o, 7'h66);
        cur = 7'h66;

        // Reset mid-shift
        capture();
        shift_bits(16'h0011, 3, rb);
        rst = 1'b1;
        ticks(1);
        check("midrst_probe", probe_o, RV);
        check("midrst_tdo", tdo_o, 0);
        rst = 1'b0;
        cur = RV;
        shift_i = 1'b0;
        ticks(HALF);
        run_txn("post_rst", 16'h0019, LEN, 1'b1, 1'b0, 7'h19, cur);

        // Randomized transactions against the probe-register model
        for (int i = 0; i < 30; i++) begin
            d = 16'($urandom & 32'h7F);
            r = int'($urandom_range(0, 4));
            n = (r == 0) ? LEN - 1 : (r == 1) ? LEN + 1 : LEN;
            if (n == LEN) run_txn($sformatf("rnd%0d", i), d, n, 1'b1, 1'b0, d[W-1:0], cur);
            else          run_txn($sformatf("rnd%0d", i), d, n, 1'b0, 1'b1, cur, cur);
        end

`ifdef VIO_PULSE_EN
        // Level 0x01, then a pulse of 0x7F lasting PL cycles before reverting
        run_txn("lvl", 16'h0001, LEN, 1'b1, 1'b0, 7'h01, cur);
        capture();
        shift_bits(16'h00FF, LEN, rb);
        update_i = 1'b1;
        lat = -1;
        for (int k = 1; k <= 24 && lat < 0; k++) begin
            ticks(1);
            if (probe_valid_o) lat = k;
        end
        check("pulse_latency", lat, SS + 2);
        cnt = 0;
        while (probe_o == 7'h7F && cnt < 3 * PL) begin
            cnt++;
            ticks(1);
        end
        check("pulse_len", cnt, PL);
        check("pulse_revert", probe_o, 7'h01);
        update_i = 1'b0; shift_i = 1'b0;
        ticks(HALF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gao_vio_driver.md
Name: gao_vio_driver

Overview:
- Write-direction companion to the in-design GAO capture path. That path reads internal probes out over JTAG; this block lets the host drive WIDTH virtual input bits into the design over the same JTAG user-register signals.
- JTAG pins (tck/tdi/shift/update/enable) are oversampled in the system clk domain. Shifted words are assembled, length-checked and committed to probe_o atomically on update.
- The current probe_o value is shifted back out on tdo_o for host readback.
- Instantiated beside the GAO core, driven from the GW_JTAG ER2 user-register outputs.

Parameters:
- WIDTH, 7, number of virtual probe bits driven into the design.
- SYNC_STAGES, 2, flip-flop stages in each JTAG input synchronizer (minimum 2).
- RESET_VAL, 0, value of probe_o after reset (WIDTH bits).
- PULSE_LEN, 16, clk cycles a pulse-mode commit stays asserted (VIO_PULSE_EN only; >=1).

Ports:
- clk  in  1  system clock; must be >= 4x tck frequency.
- rst  in  1  synchronous, active-high reset.
- tck_i  in  1  JTAG TCK from the TAP (asynchronous to clk).
- tdi_i  in  1  JTAG TDI.
- enable_i  in  1  user register selected (enable_er2).
- shift_i  in  1  shift_dr_capture_dr from the TAP.
- update_i  in  1  update_dr from the TAP.
- tdo_o  out  1  serial readback to tdo_er2_i.
- probe_o  out  WIDTH  committed virtual input value.
- probe_valid_o  out  1  one-cycle pulse on each accepted commit.
- len_err_o  out  1  one-cycle pulse when an update is rejected for wrong bit count.

Behaviour:
- Reset:
  - probe_o = RESET_VAL; tdo_o = 0; probe_valid_o = 0; len_err_o = 0.
  - shadow register = 0; bit_cnt = 0; FSM in IDLE.
- Input synchronization and edge detection:
  - All five JTAG inputs pass through SYNC_STAGES flops.
  - Edge detection uses one extra registered copy of each synchronized input.
  - tck_rise / tck_fall, shift_rise and update_rise are single-clk pulses.
- FSM states:
  - IDLE: on shift_rise with enable -> CAPTURE.
  - CAPTURE (1 cycle): shadow <= probe_o; bit_cnt <= 0; tdo_o <= probe_o[0]; -> SHIFT.
  - SHIFT:
    - On tck_rise with enable & shift: shadow <= {tdi, shadow[WIDTH-1:1]} (LSB-first) and bit_cnt++. bit_cnt saturates at WIDTH+1.
    - On tck_fall: tdo_o <= shadow[0].
    - On update_rise with enable: -> UPDATE.
    - Loss of enable -> IDLE, and the shadow is discarded.
  - UPDATE (1 cycle):
    - If bit_cnt == WIDTH: probe_o <= shadow and probe_valid_o = 1 for this cycle.
    - Otherwise probe_o is unchanged and len_err_o = 1.
    - Then -> IDLE.
- update_rise seen in IDLE (no shift since the last commit) is ignored, with no pulse on either output.
- shift_rise in SHIFT (re-capture without update) re-enters CAPTURE: shadow is reloaded and bit_cnt cleared.
- Simultaneous tck_rise and update_rise in SHIFT: the shift is applied first, then the count check in UPDATE includes that bit.
- probe_o only ever changes in UPDATE (or on reset), so the design never sees a partially shifted word.
- Latency: probe_o changes SYNC_STAGES+2 clk cycles after update_i rises.
- tdo_o changes only in CAPTURE or on tck_fall; it holds its value otherwise.
- rst during any state returns to IDLE next cycle with reset values. A shift in progress is lost, and the host must restart from capture.

Optional Feature:
- Macro VIO_PULSE_EN.
- When defined:
  - Shift length becomes WIDTH+1 bits; the extra MSB is a mode bit.
  - Mode=0: level commit, identical to the base behaviour.
  - Mode=1: probe_o <= shadow for exactly PULSE_LEN clk cycles, then reverts to the previous level value.
  - A new accepted commit during an active pulse restarts the timer; the revert target is the last level-mode value.
  - Reset clears the timer.
- When undefined:
  - Shift length is WIDTH bits.
  - No pulse counter or revert register is synthesized.

Test Plan:
- Reset then idle 20 cycles -> probe_o = 0, tdo_o = 0, no pulses on probe_valid_o or len_err_o.
- Capture, then shift 7 bits LSB-first of 7'h5A, then update -> probe_o = 7'h5A after SYNC_STAGES+2 clks; probe_valid_o high exactly 1 cycle.
- With probe_o = 7'h5A, capture and shift 7'h00 in -> tdo_o sequence observed on tck falls = 0,1,0,1,1,0,1 (LSB first); final probe_o = 0.
- Shift 6 bits, update -> len_err_o 1 cycle, probe_o unchanged; repeat with 8 bits -> same result.
- Drop enable_i mid-shift after 3 bits, then assert update_i -> no commit, no error, FSM returns to IDLE; assert rst mid-shift -> probe_o = RESET_VAL next cycle.
- VIO_PULSE_EN, PULSE_LEN=16: level-commit 7'h01, then pulse-commit 7'h7F -> probe_o = 7'h7F for exactly 16 clks, then 7'h01.
